bf_prog_loader: RTL and testbench
=================================

Name: bf_prog_loader

Overview:
UART-fed program loader in front of the TinyBF core's program-upload port (prog_we/prog_waddr/prog_wdata). It consumes received bytes from a uart_rx byte stream, parses a framed upload packet, and writes the payload into program memory one byte per cycle. A checksum is verified at the end of the frame. On a good frame it can optionally pulse start to the CPU. Bytes arriving while the CPU is busy are dropped.

Parameters:
ADDR_W, 4, program memory address width; capacity DEPTH = 2**ADDR_W bytes
SYNC_BYTE, 8'hB5, frame header value
TIMEOUT_CYCLES, 8680, maximum idle clk_i cycles between bytes inside a frame (about 2 byte times at 50 MHz / 115200 baud)
AUTO_START, 1, when 1, pulse start_o after a frame that passes checksum

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-low reset
rx_valid_i  input  1  one-cycle strobe, new byte on rx_data_i
rx_data_i  input  8  received byte
cpu_busy_i  input  1  CPU executing; loader ignores frames while high
prog_we_o  output  1  program memory write enable (one-cycle pulse)
prog_waddr_o  output  ADDR_W  write address
prog_wdata_o  output  8  write data (raw received byte)
start_o  output  1  one-cycle start pulse to CPU
load_busy_o  output  1  high while a frame is in progress
load_done_o  output  1  one-cycle pulse, frame accepted (checksum ok)
load_err_o  output  1  sticky error flag; cleared by the next accepted SYNC_BYTE or by reset

Behaviour:
- Reset (rst_i low at a clk_i edge): state IDLE. All outputs 0. Address counter, length, checksum and timeout counter cleared. A reset mid-frame abandons the frame. Memory writes already made are not undone.
- Frame format: SYNC_BYTE, LEN (1..DEPTH), LEN payload bytes, CHK. CHK is the XOR of all payload bytes.
- FSM states: IDLE, LEN, DATA, CHK, DONE.
- IDLE:
  - rx_valid_i with rx_data_i==SYNC_BYTE and cpu_busy_i=0 -> go to LEN and clear load_err_o.
  - Any other byte, or a SYNC_BYTE while cpu_busy_i=1, is ignored.
- LEN:
  - LEN==0 or LEN>DEPTH -> set load_err_o and return to IDLE.
  - Otherwise store LEN, clear addr and checksum, go to DATA.
- DATA, on each rx_valid_i:
  - Registered outputs: prog_we_o=1 the following cycle (latency 1), prog_waddr_o=addr, prog_wdata_o=byte.
  - checksum ^= byte; addr increments.
  - After the LEN-th byte go to CHK.
  - addr never wraps: LEN<=DEPTH bounds it.
- CHK:
  - Byte==checksum -> go to DONE.
  - Otherwise set load_err_o and go to IDLE; no start, no done.
- DONE: lasts one cycle. Pulse load_done_o; pulse start_o when AUTO_START=1. Return to IDLE.
- load_busy_o = 1 in LEN, DATA, CHK, DONE.
- prog_we_o is 0 in every state except the cycle after a DATA byte.
- Timeout:
  - Counter resets on every rx_valid_i and counts in LEN, DATA, CHK.
  - Reaching TIMEOUT_CYCLES -> set load_err_o and return to IDLE.
- cpu_busy_i rising mid-frame does not abort the frame; the gate applies only at the header.
- rx_valid_i in DONE is dropped.
- A SYNC_BYTE seen inside LEN, DATA or CHK is treated as ordinary data; there is no resync.
- start_o and load_done_o are single-cycle, never back-to-back.

Decomposition:
- Package bf_loader_pkg:
  - State enum (IDLE, LEN, DATA, CHK, DONE).
  - Default SYNC_BYTE.
  - Helper constant for timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module bf_timeout_ctr: loadable saturating down-counter with clear and expire outputs. Reusable by the UART RX stage.
- The rest is one FSM module.

Test Plan:
- Good frame, DEPTH=16: B5, 03, 2B, 2E, 5B, CHK=5E -> three prog_we_o pulses: addr0=2B, addr1=2E, addr2=5B, each one cycle after its rx_valid_i. load_done_o and start_o pulse once. load_err_o=0.
- Bad checksum: B5, 02, 2B, 2B, CHK=01 (expected 00) -> two writes occur. load_err_o=1, no start_o, FSM in IDLE. A following good frame clears load_err_o at its SYNC byte.
- Length bounds:
  - B5, 00 -> load_err_o=1, no writes.
  - B5, 11 -> load_err_o=1, no writes.
  - B5, 10 plus 16 bytes plus correct CHK -> writes addr 0..15 with no wrap; done pulses.
- Busy gating: cpu_busy_i=1 while B5, 01, 2B, CHK sent -> no writes, load_busy_o stays 0. Same bytes with cpu_busy_i=0 -> accepted.
- Timeout: B5, 02, 2B, then silence for TIMEOUT_CYCLES -> load_err_o=1, IDLE, one write only. A later SYNC is accepted.
- Reset mid-frame: rst_i low for 1 cycle after the first DATA byte -> all outputs 0 next cycle, IDLE. The remaining bytes are ignored until a new SYNC_BYTE.

Source files
------------

// File: rtl/bf_loader_pkg.sv
// Shared types and constants for the TinyBF UART program loader.
package bf_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hB5;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 8680;

    // Counter width able to hold the value `cycles` itself.
    function automatic int unsigned tmo_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/bf_timeout_ctr.sv
// Loadable saturating down-counter; expired_c is high once the count reaches zero.
module bf_timeout_ctr #(
    parameter int unsigned W = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_c
);

    logic [W-1:0] cnt_q;

    // Load wins over clear so a reload on the same cycle is never lost.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/bf_prog_loader.sv
// Framed UART program loader: SYNC, LEN, payload, XOR checksum -> program memory writes.
module bf_prog_loader
    import bf_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 4,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              cpu_busy_i,
    output logic              prog_we_o,
    output logic [ADDR_W-1:0] prog_waddr_o,
    output logic [7:0]        prog_wdata_o,
    output logic              start_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned TO_W  = tmo_width(TIMEOUT_CYCLES);

    state_t             state_q, state_next;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic               err_d, we_d;
    logic [ADDR_W-1:0]  waddr_d;
    logic [7:0]         wdata_d;

    logic               in_frame_c, sync_ok_c, len_bad_c, last_c;
    logic               tmo_load_c, tmo_clr_c, tmo_exp_c, tmo_hit_c;
    logic [LEN_W-1:0]   cnt_inc_c;

    assign in_frame_c = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign sync_ok_c  = rx_valid_i && (rx_data_i == SYNC_BYTE) && !cpu_busy_i;
    assign len_bad_c  = (rx_data_i == 8'd0) || (32'(rx_data_i) > DEPTH);
    assign cnt_inc_c  = cnt_q + LEN_W'(1);
    assign last_c     = (cnt_inc_c == len_q);

    // Inter-byte watchdog: reloaded by every byte of a frame, idles outside one.
    assign tmo_load_c = ((state_q == ST_IDLE) && sync_ok_c) || (in_frame_c && rx_valid_i);
    assign tmo_clr_c  = !in_frame_c && !tmo_load_c;
    assign tmo_hit_c  = in_frame_c && !rx_valid_i && tmo_exp_c;

    bf_timeout_ctr #(
        .W (TO_W)
    ) u_tmo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (tmo_clr_c),
        .load_i     (tmo_load_c),
        .load_val_i (TO_W'(TIMEOUT_CYCLES)),
        .en_i       (in_frame_c),
        .expired_c  (tmo_exp_c)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (sync_ok_c) state_next = ST_LEN;
            ST_LEN: begin
                if (rx_valid_i)     state_next = len_bad_c ? ST_IDLE : ST_DATA;
                else if (tmo_hit_c) state_next = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_valid_i)     state_next = last_c ? ST_CHK : ST_DATA;
                else if (tmo_hit_c) state_next = ST_IDLE;
            end
            ST_CHK: begin
                if (rx_valid_i)     state_next = (rx_data_i == chk_q) ? ST_DONE : ST_IDLE;
                else if (tmo_hit_c) state_next = ST_IDLE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        err_d   = load_err_o;
        we_d    = 1'b0;
        waddr_d = prog_waddr_o;
        wdata_d = prog_wdata_o;
        if (tmo_hit_c) err_d = 1'b1;
        case (state_q)
            ST_IDLE: if (sync_ok_c) err_d = 1'b0;
            ST_LEN: begin
                if (rx_valid_i) begin
                    if (len_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        len_d = LEN_W'(rx_data_i);
                        cnt_d = '0;
                        chk_d = 8'd0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = rx_data_i;
                    chk_d   = chk_q ^ rx_data_i;
                    cnt_d   = cnt_inc_c;
                end
            end
            ST_CHK: if (rx_valid_i && (rx_data_i != chk_q)) err_d = 1'b1;
            default: ;
        endcase
    end

    // Registered datapath and outputs; status flags follow the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            len_q        <= '0;
            cnt_q        <= '0;
            chk_q        <= 8'd0;
            prog_we_o    <= 1'b0;
            prog_waddr_o <= '0;
            prog_wdata_o <= 8'd0;
            start_o      <= 1'b0;
            load_busy_o  <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            prog_we_o    <= we_d;
            prog_waddr_o <= waddr_d;
            prog_wdata_o <= wdata_d;
            start_o      <= AUTO_START && (state_next == ST_DONE);
            load_busy_o  <= (state_next != ST_IDLE);
            load_done_o  <= (state_next == ST_DONE);
            load_err_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Directed self-checking bench for bf_prog_loader (ADDR_W=4, default timeout).
module tb_bf_prog_loader;

    localparam int unsigned TMO = 8680;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = 8'd0;
    logic       cpu_busy_i = 1'b0;
    logic       prog_we_o;
    logic [3:0] prog_waddr_o;
    logic [7:0] prog_wdata_o;
    logic       start_o, load_busy_o, load_done_o, load_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    int mon_wr, mon_done, mon_start, mon_busy, mon_b2b;
    logic prev_done = 1'b0;

    bf_prog_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .cpu_busy_i   (cpu_busy_i),
        .prog_we_o    (prog_we_o),
        .prog_waddr_o (prog_waddr_o),
        .prog_wdata_o (prog_wdata_o),
        .start_o      (start_o),
        .load_busy_o  (load_busy_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Event counters sampled mid-cycle.
    always @(negedge clk_i) begin
        if (prog_we_o === 1'b1)   mon_wr++;
        if (load_done_o === 1'b1) mon_done++;
        if (start_o === 1'b1)     mon_start++;
        if (load_busy_o === 1'b1) mon_busy++;
        if (prev_done && (load_done_o === 1'b1)) mon_b2b++;
        prev_done = (load_done_o === 1'b1);
    end

    task automatic clear_mon();
        mon_wr = 0; mon_done = 0; mon_start = 0; mon_busy = 0;
    endtask

    // One-cycle byte strobe; returns 1 time unit after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle(3);
        n_tests++;
        if ({prog_we_o, prog_waddr_o, prog_wdata_o, start_o, load_busy_o, load_done_o, load_err_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h st=%b busy=%b done=%b err=%b, want all 0",
                     prog_we_o, prog_waddr_o, prog_wdata_o, start_o, load_busy_o, load_done_o, load_err_o);
        end
        rst_i = 1'b1;
        idle(1);
    endtask

    task automatic test_good_frame();
        logic [7:0] pay [3];
        pay[0] = 8'h2B; pay[1] = 8'h2E; pay[2] = 8'h5B;
        clear_mon();
        send_byte(8'hB5);
        n_tests++;
        if (load_busy_o !== 1'b1) begin n_fail++; $display("FAIL good_busy_after_sync: got %b want 1", load_busy_o); end
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(pay[i]);
            n_tests++;
            if (prog_we_o !== 1'b1 || prog_waddr_o !== 4'(i) || prog_wdata_o !== pay[i]) begin
                n_fail++;
                $display("FAIL good_write%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         i, prog_we_o, prog_waddr_o, prog_wdata_o, 4'(i), pay[i]);
            end
        end
        send_byte(8'h5E);
        n_tests++;
        if (load_done_o !== 1'b1 || start_o !== 1'b1 || load_err_o !== 1'b0 || prog_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL good_done: got done=%b start=%b err=%b we=%b want 1 1 0 0", load_done_o, start_o, load_err_o, prog_we_o);
        end
        idle(2);
        n_tests++;
        if (mon_wr !== 3 || mon_done !== 1 || mon_start !== 1 || load_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL good_counts: got wr=%0d done=%0d start=%0d busy=%b want 3 1 1 0", mon_wr, mon_done, mon_start, load_busy_o);
        end
    endtask

    task automatic test_bad_chk();
        clear_mon();
        send_byte(8'hB5); send_byte(8'h02); send_byte(8'h2B); send_byte(8'h2B); send_byte(8'h01);
        idle(2);
        n_tests++;
        if (load_err_o !== 1'b1 || load_busy_o !== 1'b0 || mon_wr !== 2 || mon_start !== 0 || mon_done !== 0) begin
            n_fail++;
            $display("FAIL bad_chk: got err=%b busy=%b wr=%0d start=%0d done=%0d want 1 0 2 0 0",
                     load_err_o, load_busy_o, mon_wr, mon_start, mon_done);
        end
        send_byte(8'hB5);
        n_tests++;
        if (load_err_o !== 1'b0) begin n_fail++; $display("FAIL bad_chk_err_clear: got %b want 0", load_err_o); end
        send_byte(8'h01); send_byte(8'h2B); send_byte(8'h2B);
        n_tests++;
        if (load_done_o !== 1'b1) begin n_fail++; $display("FAIL bad_chk_recover: got done=%b want 1", load_done_o); end
        idle(2);
    endtask

    task automatic test_len_bounds();
        logic [7:0] lens [2];
        logic [7:0] chk;
        logic [7:0] b;
        lens[0] = 8'h00; lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_byte(8'hB5); send_byte(lens[k]);
            idle(2);
            n_tests++;
            if (load_err_o !== 1'b1 || load_busy_o !== 1'b0 || mon_wr !== 0) begin
                n_fail++;
                $display("FAIL len_bad_%h: got err=%b busy=%b wr=%0d want 1 0 0", lens[k], load_err_o, load_busy_o, mon_wr);
            end
        end
        clear_mon();
        chk = 8'h00;
        send_byte(8'hB5); send_byte(8'h10);
        n_tests++;
        if (load_err_o !== 1'b0) begin n_fail++; $display("FAIL len16_accept: got err=%b want 0", load_err_o); end
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 37 + 11);
            chk = chk ^ b;
            send_byte(b);
            n_tests++;
            if (prog_we_o !== 1'b1 || prog_waddr_o !== 4'(i) || prog_wdata_o !== b) begin
                n_fail++;
                $display("FAIL len16_write%0d: got we=%b addr=%h data=%h want 1 %h %h", i, prog_we_o, prog_waddr_o, prog_wdata_o, 4'(i), b);
            end
        end
        send_byte(chk);
        n_tests++;
        if (load_done_o !== 1'b1 || mon_wr !== 16) begin
            n_fail++;
            $display("FAIL len16_done: got done=%b wr=%0d want 1 16", load_done_o, mon_wr);
        end
        idle(2);
    endtask

    task automatic test_busy_gate();
        clear_mon();
        cpu_busy_i = 1'b1;
        send_byte(8'hB5); send_byte(8'h01); send_byte(8'h2B); send_byte(8'h2B);
        idle(2);
        n_tests++;
        if (mon_wr !== 0 || mon_busy !== 0 || mon_done !== 0) begin
            n_fail++;
            $display("FAIL busy_gate: got wr=%0d busy_cycles=%0d done=%0d want 0 0 0", mon_wr, mon_busy, mon_done);
        end
        cpu_busy_i = 1'b0;
        send_byte(8'hB5);
        cpu_busy_i = 1'b1;
        send_byte(8'h01); send_byte(8'h2B); send_byte(8'h2B);
        n_tests++;
        if (load_done_o !== 1'b1 || start_o !== 1'b1 || mon_wr !== 1) begin
            n_fail++;
            $display("FAIL busy_midframe: got done=%b start=%b wr=%0d want 1 1 1", load_done_o, start_o, mon_wr);
        end
        cpu_busy_i = 1'b0;
        idle(2);
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'hB5); send_byte(8'h02); send_byte(8'h2B);
        idle(TMO - 20);
        n_tests++;
        if (load_err_o !== 1'b0 || load_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got err=%b busy=%b want 0 1", load_err_o, load_busy_o);
        end
        idle(40);
        n_tests++;
        if (load_err_o !== 1'b1 || load_busy_o !== 1'b0 || mon_wr !== 1) begin
            n_fail++;
            $display("FAIL timeout_fire: got err=%b busy=%b wr=%0d want 1 0 1", load_err_o, load_busy_o, mon_wr);
        end
        send_byte(8'hB5);
        n_tests++;
        if (load_busy_o !== 1'b1 || load_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_resync: got busy=%b err=%b want 1 0", load_busy_o, load_err_o);
        end
        send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5A);
        idle(2);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hB5); send_byte(8'h03); send_byte(8'h2B);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        n_tests++;
        if ({prog_we_o, prog_waddr_o, prog_wdata_o, start_o, load_busy_o, load_done_o, load_err_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h data=%h st=%b busy=%b done=%b err=%b want all 0",
                     prog_we_o, prog_waddr_o, prog_wdata_o, start_o, load_busy_o, load_done_o, load_err_o);
        end
        clear_mon();
        send_byte(8'h2E); send_byte(8'h5B); send_byte(8'h5E);
        idle(2);
        n_tests++;
        if (mon_wr !== 0 || mon_busy !== 0 || mon_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_ignored: got wr=%0d busy_cycles=%0d done=%0d want 0 0 0", mon_wr, mon_busy, mon_done);
        end
        send_byte(8'hB5);
        n_tests++;
        if (load_busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_resync: got busy=%b want 1", load_busy_o); end
        send_byte(8'h01); send_byte(8'h77); send_byte(8'h77);
        n_tests++;
        if (load_done_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_frame_ok: got done=%b want 1", load_done_o); end
        idle(2);
    endtask

    initial begin
        clear_mon();
        mon_b2b = 0;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_bounds();
        test_busy_gate();
        test_timeout();
        test_reset_mid_frame();
        n_tests++;
        if (mon_b2b !== 0) begin n_fail++; $display("FAIL done_back_to_back: got %0d want 0", mon_b2b); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
